adder4_intf: RTL and testbench

Registered 4-bit ripple-carry adder with carry-in and carry-out. Its operands and results travel through a single SystemVerilog interface bundle named `inf`. It is a leaf arithmetic block: a producer drives `a`, `b` and `cin` through the interface, and consumers sample `sum` and `co` one clock later. A valid flag qualifies results so that downstream logic can ignore idle cycles.

---
 rtl/adder_pkg.sv | 18 +
 rtl/inf.sv | 35 +++
 rtl/full_adder.sv | 18 +
 rtl/adder4_intf.sv | 69 ++++++
 tb/tb_adder4_intf.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg -- shared operand/result types for the registered ripple adder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package adder_pkg;
  localparam int ADD_W = 4;

  typedef logic [ADD_W-1:0] operand_t;

  typedef struct packed {
    logic     co;
    operand_t sum;
  } result_t;
endpackage

`default_nettype wire

// File: rtl/inf.sv
// ---------------------------------------------------------------------------
// inf -- operand/result bundle between producer, adder and consumers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface inf
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_W
) (
  input logic clk,
  input logic rst_n
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             out_valid;
  logic             ovf;

  modport dut (
    input  clk, rst_n, in_valid, a, b, cin,
    output sum, co, out_valid, ovf
  );

  modport tb (
    input  clk, rst_n, sum, co, out_valid, ovf,
    output in_valid, a, b, cin
  );
endinterface

`default_nettype wire

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder -- single-bit full adder stage of the ripple chain
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

`default_nettype wire

// File: rtl/adder4_intf.sv
// ---------------------------------------------------------------------------
// adder4_intf -- registered ripple-carry adder with carry-out and overflow
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adder4_intf
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_W
) (
  inf.dut bus
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             co_d, co_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d, out_valid_q;

  assign carry[0] = bus.cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
        .a  (bus.a[i]),
        .b  (bus.b[i]),
        .ci (carry[i]),
        .s  (sum_comb[i]),
        .co (carry[i+1])
      );
    end
  endgenerate

  // Result bits hold across idle cycles; only out_valid tracks in_valid every edge.
  always_comb begin
    sum_d       = sum_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      sum_d = sum_comb;
      co_d  = carry[WIDTH];
      ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge bus.clk or negedge bus.rst_n) begin
    if (!bus.rst_n) begin
      sum_q       <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

`default_nettype wire

// File: tb/tb_adder4_intf.sv
// ---------------------------------------------------------------------------
// tb_adder4_intf -- directed and exhaustive checks of the registered adder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_adder4_intf;
  import adder_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  inf #(.WIDTH(ADD_W)) u_if (.clk(clk), .rst_n(rst_n));

  adder4_intf #(.WIDTH(ADD_W)) u_dut (.bus(u_if.dut));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {out_valid, co, ovf, sum}.
  function automatic logic [6:0] obs();
    return {u_if.out_valid, u_if.co, u_if.ovf, u_if.sum};
  endfunction

  task automatic drive(input logic v, input int a, input int b, input logic ci);
    u_if.in_valid = v;
    u_if.a        = 4'(a);
    u_if.b        = 4'(b);
    u_if.cin      = ci;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst_n = 1'b1;
    drive(1'b1, 9, 9, 1'b1);
    tick();
    tick();
    // Registers now hold 9+9+1; assert reset away from any edge.
    #2;
    rst_n = 1'b0;
    #1;
    got = obs();
    checks++;
    if (got !== 7'b000_0000) begin
      errors++;
      $display("FAIL reset_async got=%b want=%b", got, 7'b000_0000);
    end
    drive(1'b1, 5, 2, 1'b0);
    tick();
    got = obs();
    checks++;
    if (got !== 7'b000_0000) begin
      errors++;
      $display("FAIL reset_held_edge got=%b want=%b", got, 7'b000_0000);
    end
    #2;
    rst_n = 1'b1;
    tick();
    got = obs();
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 4'd7}) begin
      errors++;
      $display("FAIL reset_release_first_capture got=%b want=%b", got, {1'b1, 1'b0, 1'b0, 4'd7});
    end
  endtask

  task automatic test_directed();
    int         va [8] = '{0, 5, 14, 8, 5, 15, 0, 7};
    int         vb [8] = '{0, 2, 4, 4, 10, 15, 0, 1};
    logic       vc [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
    logic [3:0] es [8] = '{4'd0, 4'd7, 4'd2, 4'd12, 4'd15, 4'd15, 4'd1, 4'd8};
    logic       ec [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    logic       eo [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic [6:0] got;
    logic [6:0] want;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, va[i], vb[i], vc[i]);
      tick();
      got  = obs();
      want = {1'b1, ec[i], eo[i], es[i]};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL directed_%0d (%0d+%0d+%0d) got=%b want=%b", i, va[i], vb[i], vc[i], got, want);
      end
    end
  endtask

  task automatic test_hold();
    logic [6:0] got;
    drive(1'b1, 3, 4, 1'b0);
    tick();
    got = obs();
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 4'd7}) begin
      errors++;
      $display("FAIL hold_load got=%b want=%b", got, {1'b1, 1'b0, 1'b0, 4'd7});
    end
    drive(1'b0, 9, 9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      got = obs();
      checks++;
      if (got !== {1'b0, 1'b0, 1'b0, 4'd7}) begin
        errors++;
        $display("FAIL hold_idle_%0d got=%b want=%b", i, got, {1'b0, 1'b0, 1'b0, 4'd7});
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [6:0] got;
    drive(1'b1, 1, 2, 1'b0);
    tick();
    got = obs();
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 4'd3}) begin
      errors++;
      $display("FAIL midrst_before got=%b want=%b", got, {1'b1, 1'b0, 1'b0, 4'd3});
    end
    drive(1'b1, 6, 6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    got = obs();
    checks++;
    if (got !== 7'b000_0000) begin
      errors++;
      $display("FAIL midrst_async got=%b want=%b", got, 7'b000_0000);
    end
    #1;
    rst_n = 1'b1;
    tick();
    got = obs();
    checks++;
    if (got !== {1'b1, 1'b0, 1'b1, 4'd12}) begin
      errors++;
      $display("FAIL midrst_resume got=%b want=%b", got, {1'b1, 1'b0, 1'b1, 4'd12});
    end
  endtask

  task automatic test_exhaustive();
    result_t    r;
    int         sa;
    int         sb;
    int         ss;
    logic       eovf;
    logic [6:0] got;
    logic [6:0] want;
    for (int ci = 0; ci < 2; ci++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          drive(1'b1, a, b, ci[0]);
          tick();
          r    = 5'(a + b + ci);
          sa   = (a >= 8) ? a - 16 : a;
          sb   = (b >= 8) ? b - 16 : b;
          ss   = sa + sb + ci;
          eovf = (ss > 7) || (ss < -8);
          got  = obs();
          want = {1'b1, r.co, eovf, r.sum};
          checks++;
          if (got !== want) begin
            errors++;
            $display("FAIL exhaustive a=%0d b=%0d cin=%0d got=%b want=%b", a, b, ci, got, want);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    tick();
    test_reset();
    test_directed();
    test_hold();
    test_mid_reset();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
